// File: rtl/grid_display_pkg.sv
// Shared types and helpers for the 8x8 grid scan display.
package grid_display_pkg;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;
    localparam int GRID_BITS = 64;

    typedef logic [GRID_BITS-1:0] grid_t;
    typedef logic [2:0]           row_idx_t;
    typedef logic [6:0]           pop_t;

    function automatic logic [3:0] popcount8(input logic [7:0] bits);
        logic [3:0] sum;
        sum = '0;
        for (int b = 0; b < 8; b++) begin
            sum = sum + {3'b000, bits[b]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/grid_popcount.sv
// Combinational population count of a 64-bit grid: byte counts, then a 3-level adder tree.
module grid_popcount
    import grid_display_pkg::*;
(
    input  grid_t grid_i,
    output pop_t  count_o
);

    logic [3:0] byte_cnt [8];
    logic [4:0] pair_cnt [4];
    logic [5:0] quad_cnt [2];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign byte_cnt[gi] = popcount8(grid_i[8*gi +: 8]);
        end
        for (gi = 0; gi < 4; gi++) begin : g_pair
            assign pair_cnt[gi] = {1'b0, byte_cnt[2*gi]} + {1'b0, byte_cnt[2*gi+1]};
        end
        for (gi = 0; gi < 2; gi++) begin : g_quad
            assign quad_cnt[gi] = {1'b0, pair_cnt[2*gi]} + {1'b0, pair_cnt[2*gi+1]};
        end
    endgenerate

    assign count_o = {1'b0, quad_cnt[0]} + {1'b0, quad_cnt[1]};

endmodule

// File: rtl/grid_scan_display.sv
// Row-multiplexed 8x8 LED driver with frame-boundary double buffering and grid status.
// Optional PWM_DIM_EN adds a brightness input that shortens the lit window per row.
module grid_scan_display
    import grid_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [GRID_BITS-1:0] grid_in,
    input  logic                 grid_valid,
`ifdef PWM_DIM_EN
    input  logic [2:0]           brightness,
`endif
    output logic [GRID_ROWS-1:0] row_n,
    output logic [GRID_COLS-1:0] col,
    output logic                 frame_start,
    output logic [6:0]           population,
    output logic                 extinct,
    output logic                 stable
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(BLANK_CYCLES);

    grid_t            pending_q, pending_d;
    grid_t            display_q, display_d;
    grid_t            prev_q, prev_d;
    logic             pending_full_q, pending_full_d;
    logic             swapped_q, swapped_d;
    row_idx_t         row_idx_q, row_idx_d;
    logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;

    logic [7:0] row_n_q, col_q;
    logic       frame_start_q, extinct_q, stable_q;
    pop_t       population_q, pop_count;

    logic dwell_last, swap, col_on;

    assign dwell_last = (dwell_cnt_q == DWELL_LAST);
    assign swap       = dwell_last && (row_idx_q == 3'd7) && pending_full_q;

`ifdef PWM_DIM_EN
    logic [2:0]  bright_q, bright_eff;
    logic [31:0] on_end;

    // Brightness takes effect at dwell 0 so a row never changes level mid-dwell.
    assign bright_eff = (dwell_cnt_q == '0) ? brightness : bright_q;
    assign on_end = 32'(BLANK_CYCLES)
                  + ((32'(DWELL_CYCLES - BLANK_CYCLES) * (32'(bright_eff) + 32'd1)) >> 3);
    assign col_on = (dwell_cnt_q >= BLANK_START) && (32'(dwell_cnt_q) < on_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= 3'd0;
        end else begin
            bright_q <= bright_eff;
        end
    end
`else
    assign col_on = (dwell_cnt_q >= BLANK_START);
`endif

    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        display_d      = display_q;
        prev_d         = prev_q;
        swapped_d      = swapped_q;
        dwell_cnt_d    = dwell_last ? '0 : dwell_cnt_q + 1'b1;
        row_idx_d      = dwell_last ? row_idx_q + 1'b1 : row_idx_q;
        if (swap) begin
            prev_d         = display_q;
            display_d      = pending_q;
            pending_full_d = 1'b0;
            swapped_d      = 1'b1;
        end
        // A strobe in the swap cycle refills pending after the old value moved out.
        if (grid_valid) begin
            pending_d      = grid_in;
            pending_full_d = 1'b1;
        end
    end

    grid_popcount u_popcount (
        .grid_i  (display_q),
        .count_o (pop_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q      <= '0;
            display_q      <= '0;
            prev_q         <= '0;
            pending_full_q <= 1'b0;
            swapped_q      <= 1'b0;
            row_idx_q      <= '0;
            dwell_cnt_q    <= '0;
            row_n_q        <= 8'hFF;
            col_q          <= 8'h00;
            frame_start_q  <= 1'b0;
            population_q   <= '0;
            extinct_q      <= 1'b1;
            stable_q       <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            display_q      <= display_d;
            prev_q         <= prev_d;
            pending_full_q <= pending_full_d;
            swapped_q      <= swapped_d;
            row_idx_q      <= row_idx_d;
            dwell_cnt_q    <= dwell_cnt_d;
            row_n_q        <= ~(8'h01 << row_idx_q);
            col_q          <= col_on ? display_q[{row_idx_q, 3'b000} +: 8] : 8'h00;
            frame_start_q  <= (row_idx_q == 3'd0) && (dwell_cnt_q == '0);
            population_q   <= pop_count;
            extinct_q      <= (display_q == '0);
            stable_q       <= swapped_q && (display_q == prev_q);
        end
    end

    assign row_n       = row_n_q;
    assign col         = col_q;
    assign frame_start = frame_start_q;
    assign population  = population_q;
    assign extinct     = extinct_q;
    assign stable      = stable_q;

endmodule

// File: doc/grid_scan_display.md
Name: grid_scan_display

Overview:
- Downstream consumer of the Game of Life engine's 64-bit generation output. Drives an 8x8 LED matrix by multiplexing one row at a time.
- Double-buffers incoming generations so the image only changes at a frame boundary, which prevents tearing.
- Reports population, extinction and still-life status for the top-level FSM and the status LEDs.

Parameters:
- DWELL_CYCLES, 1000, clk cycles each row stays lit (min 4).
- BLANK_CYCLES, 2, cycles at the start of each row dwell with columns forced off (anti-ghosting); must be < DWELL_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- grid_in  in  64  generation from engine; bit 8*r+c = row r, column c
- grid_valid  in  1  one-cycle strobe: grid_in holds a new generation
- row_n  out  8  one-hot active-low row select
- col  out  8  column drive for active row, active-high; bit c = column c
- frame_start  out  1  one-cycle pulse coincident with row 0 becoming active
- population  out  7  live-cell count of displayed grid, 0..64
- extinct  out  1  displayed grid is all zero
- stable  out  1  last swap loaded a grid identical to the one it replaced
- brightness  in  3  only present with PWM_DIM_EN

Behaviour:
- Reset (async assert, sync release) clears:
  - pending, display and prev buffers to 0
  - pending_full, row_idx, dwell_cnt to 0
  - outputs: row_n=8'hFF, col=0, frame_start=0, population=0, extinct=1, stable=0
- Capture:
  - grid_valid=1 loads pending<=grid_in and sets pending_full.
  - A later strobe before the swap overwrites pending (latest wins; no backpressure).
- Scan:
  - dwell_cnt counts 0..DWELL_CYCLES-1. At its terminal value it wraps and row_idx increments mod 8.
  - Frame boundary = terminal count with row_idx=7.
- Swap, at the frame boundary when pending_full=1:
  - prev<=display; display<=pending; pending_full<=0.
  - If grid_valid occurs in the same cycle, the new grid_in goes to pending, pending_full stays 1, and the old pending is swapped in.
  - With no pending data, display holds.
- Status:
  - population, extinct and stable are registered one cycle after the swap; they are stable for the whole frame.
  - population = popcount(display). extinct = (display==0).
  - stable = (display==prev), and is only set once at least one swap has occurred since reset.
- Outputs are registered, one cycle behind the counters:
  - row_n = ~(1<<row_idx).
  - col = display[8*row_idx +: 8] when dwell_cnt >= BLANK_CYCLES, else 0.
  - frame_start = 1 in the cycle row_n first shows 8'hFE in each frame, including the first frame after reset.
- Frame period: 8*DWELL_CYCLES cycles.
- Reset mid-frame: scan restarts at row 0 on release; any pending grid is discarded.

Optional Feature:
- Macro: PWM_DIM_EN.
- Enabled:
  - brightness port exists.
  - col is non-zero only while BLANK_CYCLES <= dwell_cnt < BLANK_CYCLES + (((DWELL_CYCLES-BLANK_CYCLES)*(brightness+1))>>3).
  - brightness=7 equals full on; brightness is sampled at each row start.
- Disabled: port absent; columns are full on after blanking.

Decomposition:
- Package grid_display_pkg:
  - GRID_ROWS=8, GRID_COLS=8, GRID_BITS=64
  - typedef grid_t (logic [63:0]), row_idx_t (logic [2:0]), pop_t (logic [6:0])
- Sub-module grid_popcount: combinational 64-bit population count (adder tree), instantiated once on the display buffer.

Test Plan (DWELL_CYCLES=8, BLANK_CYCLES=2):
- Reset release, no grid:
  - Required: row_n steps FE,FD,...,7F every 8 cycles.
  - Required: frame_start pulses every 64 cycles; col=0; extinct=1; population=0.
- grid_valid with grid_in=64'h0000_0000_0000_00FF mid-frame:
  - Required: display unchanged until the next frame boundary.
  - Required: then row 0 col=FF from dwell cycle 2 to 7; other rows 0; population=8, extinct=0, stable=0.
- Strobe 64'h1 then 64'h3 in the same frame:
  - Required: only 64'h3 is displayed; population=2.
- Same grid 64'h0018_1800_0000_0000 delivered in two successive frames:
  - Required: stable=1 after the second swap; stable=0 after a different grid.
- grid_valid coincident with the frame-boundary cycle while pending_full=1:
  - Required: the old pending is displayed, the new one the following frame.
- Assert reset_n=0 during row 5:
  - Required: outputs go to reset values immediately.
  - Required: after release, scan restarts at row 0 and the pending grid is dropped.
- PWM_DIM_EN, brightness=3, grid all ones:
  - Required: col=FF for exactly 3 cycles per row (dwell 2..4).
